// File: rtl/dmem_bridge.sv
// dmem_bridge: M-stage data-memory bridge between the pipeline and a simple
// req/ack memory bus. It decodes loads and stores, flags misaligned
// accesses, stalls the pipeline while an access is in flight, and returns
// sign- or zero-extended load data.
// Optional feature: define DMEM_TIMEOUT_EN to add an ack watchdog. When it
// expires, the access is abandoned and bus_err pulses for one cycle.
`timescale 1ns/1ps

module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  dm_rd_ctrl,
    input  logic [1:0]  dm_wr_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall_mem,
    output logic        adel,
    output logic        ades,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        RD_NONE = 3'b000,
        RD_LW   = 3'b001,
        RD_LH   = 3'b010,
        RD_LHU  = 3'b011,
        RD_LB   = 3'b100,
        RD_LBU  = 3'b101
    } rd_op_e;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_SW   = 2'b01,
        WR_SH   = 2'b10,
        WR_SB   = 2'b11
    } wr_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // The watchdog limit must fit the 8-bit counter and be nonzero.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("dmem_bridge: TIMEOUT_CYCLES must be in 1..255");
    end

    state_e      state;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        op_go;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    // Captured at the start of the access so that the load result can be
    // formed from the request that was issued.
    logic        ld_pend;
    logic [2:0]  ld_op;
    logic [1:0]  ld_off;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]  wd_cnt;
`else
    assign bus_err = 1'b0;
`endif

    // Pick the right lane of the bus word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                                input logic [1:0]  off,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (op)
            RD_LH:   return {{16{h[15]}}, h};
            RD_LHU:  return {16'h0000, h};
            RD_LB:   return {{24{b[7]}}, b};
            RD_LBU:  return {24'h00_0000, b};
            default: return d;
        endcase
    endfunction

    // Decode the op: a store takes priority and hides any load.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (dm_wr_ctrl)
            WR_SW: begin
                is_store   = 1'b1;
                misaligned = (addr[1:0] != 2'b00);
            end
            WR_SH: begin
                is_store   = 1'b1;
                misaligned = addr[0];
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            WR_SB: begin
                is_store   = 1'b1;
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            default: begin
                case (dm_rd_ctrl)
                    RD_LW: begin
                        is_load    = 1'b1;
                        misaligned = (addr[1:0] != 2'b00);
                    end
                    RD_LH, RD_LHU: begin
                        is_load    = 1'b1;
                        misaligned = addr[0];
                    end
                    RD_LB, RD_LBU: is_load = 1'b1;
                    default: ;
                endcase
            end
        endcase
    end

    assign adel      = is_load & misaligned;
    assign ades      = is_store & misaligned;
    assign op_go     = (is_load | is_store) & ~misaligned;
    // DONE drops the stall so that the pipeline advances on the next edge.
    assign stall_mem = op_go & (state != DONE);

    // Access FSM: issue in IDLE, wait for ack in BUSY, release in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rdata     <= 32'h0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            ld_pend   <= 1'b0;
            ld_op     <= 3'b000;
            ld_off    <= 2'b00;
`ifdef DMEM_TIMEOUT_EN
            bus_err   <= 1'b0;
            wd_cnt    <= 8'h00;
`endif
        end else begin
`ifdef DMEM_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (op_go) begin
                        // NOTE: state uses non-blocking assignments, so every
                        // register updates from values sampled before the edge.
                        state     <= BUSY;
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_be    <= be_next;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wdata <= wdata_next;
                        ld_pend   <= is_load;
                        ld_op     <= dm_rd_ctrl;
                        ld_off    <= addr[1:0];
`ifdef DMEM_TIMEOUT_EN
                        wd_cnt    <= 8'h00;
`endif
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        if (ld_pend) begin
                            rdata <= load_extend(ld_op, ld_off, bus_rdata);
                        end
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (wd_cnt + 8'd1 == TIMEOUT_LIMIT) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (ld_pend) begin
                            rdata <= 32'h0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, ack-wait cycle limit (1..255); used only when DMEM_TIMEOUT_EN is defined.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 dm_rd_ctrl  in  3  M-stage load op: 000 none, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU; 110/111 treated as none.
REQ-005 dm_wr_ctrl  in  2  M-stage store op: 00 none, 01 SW, 10 SH, 11 SB.
REQ-006 addr  in  32  M-stage byte address; wdata  in  32  store data (rt).
REQ-007 rdata  out  32  extended load result; stall_mem  out  1  hold pipeline.
REQ-008 adel  out  1  load address error; ades  out  1  store address error.
REQ-009 bus_req  out  1; bus_we  out  1; bus_be  out  4; bus_addr  out  32; bus_wdata  out  32.
REQ-010 bus_rdata  in  32; bus_ack  in  1  one-cycle completion strobe from memory.
REQ-011 bus_err  out  1  one-cycle timeout pulse; driven 0 when DMEM_TIMEOUT_EN is undefined.

Function
REQ-012 Op present = dm_wr_ctrl!=00 or dm_rd_ctrl in 001..101; a nonzero store takes priority over any load, and the load is ignored.
REQ-013 Misaligned = (LW/SW and addr[1:0]!=0) or (LH/LHU/SH and addr[0]!=0); adel/ades assert combinationally in the same cycle; no bus access and no stall occur.
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 IDLE transitions to BUSY on an aligned op present; BUSY transitions to DONE on bus_ack; DONE transitions to IDLE unconditionally.
REQ-016 stall_mem = aligned op present and state!=DONE; it is combinational, so stall is asserted in the first cycle of the op.
REQ-017 bus_req=1 only in BUSY; bus_addr={addr[31:2],2'b00}; bus_we=1 for stores.
REQ-018 Bus outputs are held stable while in BUSY.
REQ-019 bus_be for SW is 1111; for SH it is 0011 when addr[1]=0 and 1100 when addr[1]=1; for SB it is 0001<<addr[1:0]; for loads it is 1111.
REQ-020 bus_wdata for SW is wdata; for SH it is {wdata[15:0],wdata[15:0]}; for SB it is four copies of wdata[7:0].
REQ-021 On bus_ack during a load, rdata is registered from bus_rdata, little-endian lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-022 rdata holds its value until the next load completes; stores leave rdata unchanged.
REQ-023 Minimum latency: bus_ack in the first BUSY cycle gives 2 stall cycles; DONE releases the stall for the advancing edge.
REQ-024 bus_ack outside BUSY is ignored.
REQ-025 No new op is sampled while in DONE.

Reset
REQ-026 When rst=0: state=IDLE, rdata=0, bus_err=0, and the watchdog counter=0, all immediately and asynchronously.
REQ-027 During reset, bus_req=0 and stall_mem follows REQ-016 with state=IDLE.
REQ-028 Reset asserted mid-BUSY abandons the access; a later bus_ack is ignored.

Configuration
REQ-029 The feature macro is DMEM_TIMEOUT_EN.
REQ-030 With DMEM_TIMEOUT_EN defined: an 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
REQ-031 With DMEM_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES, the FSM goes to DONE, bus_err pulses for 1 cycle, and rdata loads 0 for a load.
REQ-032 Without DMEM_TIMEOUT_EN: no counter exists, BUSY waits indefinitely, and bus_err is tied 0.

Verification
REQ-033 LB addr=0x103, bus_rdata=0x80FF_1234, ack after 3 BUSY cycles -> bus_addr=0x100, be=1111, 4 stall cycles, rdata=0xFFFF_FF80.
REQ-034 SH addr=0x202, wdata=0x0000_ABCD, immediate ack -> bus_we=1, be=1100, bus_wdata=0xABCD_ABCD, 2 stall cycles.
REQ-035 LW addr=0x301 -> adel=1 same cycle, bus_req=0, stall_mem=0; SB addr=0x301 -> ades=0, be=0010.
REQ-036 LHU addr=0x402, bus_rdata=0x9234_5678 -> rdata=0x0000_9234; same access as LH -> rdata=0xFFFF_9234.
REQ-037 rst pulled low mid-BUSY, then ack -> bus_req=0 immediately, state IDLE, rdata=0, ack ignored.
REQ-038 DMEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> bus_err pulses once after 4 BUSY cycles, stall releases, rdata=0.
